// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled, start-bit midpoint qualification,
// LSB-first data capture and registered character/status outputs.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | line idle, waiting for rx_sync low on a baud tick
//   START | counting to the start-bit midpoint to reject glitches
//   DATA  | sampling DATA_BITS data bits, one per 16 ticks
//   STOP  | sampling the stop bit, then publishing the character
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_x16_en,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_rdy,
  output logic                 frm_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;

  state_t                 state_q, state_d;
  logic [3:0]             over_cnt_q, over_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rdy_q, rdy_d;
  logic                   frm_err_q, frm_err_d;

  // Metastability chain on the asynchronous line; resets to idle (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      over_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      over_cnt_q <= over_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Next-state logic; everything except the ready pulse only moves on a baud tick.
  always_comb begin
    state_d    = state_q;
    over_cnt_d = over_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    frm_err_d  = frm_err_q;
    rdy_d      = 1'b0;

    if (baud_x16_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_sync) begin
            state_d    = START;
            over_cnt_d = '0;
          end
        end

        START: begin
          over_cnt_d = over_cnt_q + 4'd1;
          if (over_cnt_q == 4'd7) begin
            if (!rx_sync) begin
              state_d    = DATA;
              over_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              // Line went back high before the midpoint: treat as noise.
              state_d = IDLE;
            end
          end
        end

        DATA: begin
          over_cnt_d = over_cnt_q + 4'd1;
          if (over_cnt_q == 4'd15) begin
            shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d    = STOP;
              over_cnt_d = '0;
            end
          end
        end

        STOP: begin
          over_cnt_d = over_cnt_q + 4'd1;
          if (over_cnt_q == 4'd15) begin
            // A low stop bit still publishes the character; it is flagged, not dropped.
            rx_data_d = shift_q;
            frm_err_d = !rx_sync;
            rdy_d     = 1'b1;
            state_d   = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_data_rdy = rdy_q;
  assign frm_err     = frm_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: baud tick every 4 clk, 64 clk per bit.
module tb_uart_rx_core;

  logic       clk;
  logic       rst;
  logic       baud_x16_en;
  logic       rxd_i;
  logic [7:0] rx_data;
  logic       rx_data_rdy;
  logic       frm_err;

  int n_cmp;
  int n_bad;

  int         cyc;
  int         baud_cnt;
  int         pulse_total;
  logic [7:0] pulse_data [32];
  logic       pulse_ferr [32];
  int         pulse_at   [32];
  int         frame_start;

  uart_rx_core #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_x16_en(baud_x16_en),
    .rxd_i      (rxd_i),
    .rx_data    (rx_data),
    .rx_data_rdy(rx_data_rdy),
    .frm_err    (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp ready pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick generator: one-cycle enable every 4 clocks, driven on the falling edge.
  always @(negedge clk) begin
    baud_cnt    = (baud_cnt + 1) % 4;
    baud_x16_en = (baud_cnt == 3);
  end

  // Pulse monitor: logs every high sample of rx_data_rdy.
  always @(negedge clk) begin
    if (rx_data_rdy) begin
      pulse_data[pulse_total % 32] <= rx_data;
      pulse_ferr[pulse_total % 32] <= frm_err;
      pulse_at[pulse_total % 32]   <= cyc;
      pulse_total                  <= pulse_total + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    frame_start = cyc;
    rxd_i = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rxd_i = data[i];
      wait_clk(64);
    end
    rxd_i = stop_bit;
    wait_clk(64);
    rxd_i = 1'b1;
  endtask

  task automatic test_reset;
    int base;
    rst = 1'b1;
    rxd_i = 1'b1;
    wait_clk(5);
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    n_cmp++;
    if (rx_data_rdy !== 1'b0) begin
      n_bad++; $display("FAIL reset_rdy: got %b want 0", rx_data_rdy);
    end
    n_cmp++;
    if (frm_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_frm_err: got %b want 0", frm_err);
    end
    rst = 1'b0;
    base = pulse_total;
    wait_clk(2000);
    n_cmp++;
    if (pulse_total - base !== 0) begin
      n_bad++; $display("FAIL idle_no_pulse: got %0d pulses want 0", pulse_total - base);
    end
    n_cmp++;
    if (rx_data !== 8'h00 || frm_err !== 1'b0) begin
      n_bad++; $display("FAIL idle_outputs: got data=%h ferr=%b want 00/0", rx_data, frm_err);
    end
  endtask

  task automatic test_frame_55;
    int base;
    int dt;
    base = pulse_total;
    send_frame(8'h55, 1'b1);
    wait_clk(128);
    n_cmp++;
    if (pulse_total - base !== 1) begin
      n_bad++; $display("FAIL f55_count: got %0d pulses want 1", pulse_total - base);
    end
    n_cmp++;
    if (pulse_data[base % 32] !== 8'h55) begin
      n_bad++; $display("FAIL f55_data: got %h want 55", pulse_data[base % 32]);
    end
    n_cmp++;
    if (pulse_ferr[base % 32] !== 1'b0) begin
      n_bad++; $display("FAIL f55_ferr: got %b want 0", pulse_ferr[base % 32]);
    end
    // Stop-bit midpoint is 608 clk after the start edge; allow one bit period past it.
    dt = pulse_at[base % 32] - frame_start;
    n_cmp++;
    if (dt < 608 || dt > 672) begin
      n_bad++; $display("FAIL f55_timing: got %0d clk want 608..672", dt);
    end
    n_cmp++;
    if (rx_data !== 8'h55) begin
      n_bad++; $display("FAIL f55_hold: got %h want 55", rx_data);
    end
  endtask

  task automatic test_framing_error;
    int base;
    base = pulse_total;
    send_frame(8'hA3, 1'b0);
    wait_clk(128);
    n_cmp++;
    if (pulse_total - base !== 1) begin
      n_bad++; $display("FAIL ferr_count: got %0d pulses want 1", pulse_total - base);
    end
    n_cmp++;
    if (pulse_data[base % 32] !== 8'hA3) begin
      n_bad++; $display("FAIL ferr_data: got %h want a3", pulse_data[base % 32]);
    end
    n_cmp++;
    if (frm_err !== 1'b1) begin
      n_bad++; $display("FAIL ferr_flag: got %b want 1", frm_err);
    end
    base = pulse_total;
    send_frame(8'h3C, 1'b1);
    wait_clk(128);
    n_cmp++;
    if (pulse_total - base !== 1) begin
      n_bad++; $display("FAIL good_after_ferr_count: got %0d pulses want 1", pulse_total - base);
    end
    n_cmp++;
    if (rx_data !== 8'h3C) begin
      n_bad++; $display("FAIL good_after_ferr_data: got %h want 3c", rx_data);
    end
    n_cmp++;
    if (frm_err !== 1'b0) begin
      n_bad++; $display("FAIL good_after_ferr_flag: got %b want 0", frm_err);
    end
  endtask

  task automatic test_glitch;
    int base;
    int dt;
    base = pulse_total;
    rxd_i = 1'b0;
    wait_clk(16);
    rxd_i = 1'b1;
    wait_clk(256);
    n_cmp++;
    if (pulse_total - base !== 0) begin
      n_bad++; $display("FAIL glitch_no_pulse: got %0d pulses want 0", pulse_total - base);
    end
    n_cmp++;
    if (rx_data !== 8'h3C) begin
      n_bad++; $display("FAIL glitch_data_held: got %h want 3c", rx_data);
    end
    send_frame(8'h96, 1'b1);
    wait_clk(128);
    n_cmp++;
    if (pulse_total - base !== 1 || pulse_data[base % 32] !== 8'h96) begin
      n_bad++; $display("FAIL post_glitch_frame: got %0d pulses data %h want 1 pulse 96",
                        pulse_total - base, pulse_data[base % 32]);
    end
    dt = pulse_at[base % 32] - frame_start;
    n_cmp++;
    if (dt < 608 || dt > 672) begin
      n_bad++; $display("FAIL post_glitch_timing: got %0d clk want 608..672", dt);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = pulse_total;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(128);
    n_cmp++;
    if (pulse_total - base !== 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d pulses want 2", pulse_total - base);
    end
    n_cmp++;
    if (pulse_data[base % 32] !== 8'h00 || pulse_ferr[base % 32] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_first: got %h/%b want 00/0",
                        pulse_data[base % 32], pulse_ferr[base % 32]);
    end
    n_cmp++;
    if (pulse_data[(base + 1) % 32] !== 8'hFF || pulse_ferr[(base + 1) % 32] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second: got %h/%b want ff/0",
                        pulse_data[(base + 1) % 32], pulse_ferr[(base + 1) % 32]);
    end
    n_cmp++;
    if (pulse_at[(base + 1) % 32] - pulse_at[base % 32] !== 640) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d clk want 640",
                        pulse_at[(base + 1) % 32] - pulse_at[base % 32]);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] partial;
    int base;
    partial = 8'h81;
    base = pulse_total;
    @(negedge clk);
    rxd_i = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 3; i++) begin
      rxd_i = partial[i];
      wait_clk(64);
    end
    rxd_i = partial[3];
    wait_clk(32);
    rst = 1'b1;
    rxd_i = 1'b1;
    wait_clk(10);
    n_cmp++;
    if (rx_data !== 8'h00 || rx_data_rdy !== 1'b0 || frm_err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs: got data=%h rdy=%b ferr=%b want 00/0/0",
                        rx_data, rx_data_rdy, frm_err);
    end
    rst = 1'b0;
    wait_clk(256);
    n_cmp++;
    if (pulse_total - base !== 0) begin
      n_bad++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulse_total - base);
    end
    send_frame(8'h7E, 1'b1);
    wait_clk(128);
    n_cmp++;
    if (pulse_total - base !== 1) begin
      n_bad++; $display("FAIL midrst_count: got %0d pulses want 1", pulse_total - base);
    end
    n_cmp++;
    if (rx_data !== 8'h7E || frm_err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_data: got %h/%b want 7e/0", rx_data, frm_err);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    cyc         = 0;
    baud_cnt    = 0;
    pulse_total = 0;
    frame_start = 0;
    baud_x16_en = 1'b0;
    rxd_i       = 1'b1;
    rst         = 1'b1;

    test_reset();
    test_frame_55();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal range 5..8).
REQ-002 Parameter SYNC_STAGES, default 2, number of metastability flops on rxd_i (minimum 2).
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rst, input, 1, reset that SHALL be asynchronous and active-high; no other clock or reset exists.
REQ-005 Port baud_x16_en, input, 1, single-cycle enable from the baud generator, asserted 16 times per bit period.
REQ-006 Port rxd_i, input, 1, asynchronous serial line; idle high.
REQ-007 Port rx_data, output, DATA_BITS, last received character, LSB first on the line.
REQ-008 Port rx_data_rdy, output, 1, one-clk pulse marking a new rx_data value.
REQ-009 Port frm_err, output, 1, stop-bit status of the character currently on rx_data.

Function
REQ-010 rxd_i SHALL pass through SYNC_STAGES flops, all reset to 1; rx_sync is the last stage's output, and all sampling uses rx_sync only.
REQ-011 The FSM states SHALL be IDLE, START, DATA and STOP; over_cnt (4 bits) and bit_cnt (3 bits) change only on clocks where baud_x16_en=1.
REQ-012 IDLE: on a baud_x16_en cycle with rx_sync=0, the FSM SHALL go to START with over_cnt cleared to 0; otherwise it stays in IDLE.
REQ-013 START: on each enable cycle, over_cnt SHALL increment; on the enable cycle where over_cnt=7 (bit midpoint), rx_sync=0 goes to DATA with over_cnt=0 and bit_cnt=0, and rx_sync=1 returns to IDLE (glitch rejected, no output change).
REQ-014 DATA: on each enable cycle, over_cnt SHALL increment and wrap 15->0.
REQ-015 DATA: on the enable cycle where over_cnt=15, rx_sync SHALL shift into the shift register MSB so the first bit ends at LSB, and bit_cnt SHALL increment.
REQ-016 DATA: after the DATA_BITS-th sample, the FSM SHALL go to STOP with over_cnt=0.
REQ-017 STOP: on the enable cycle where over_cnt=15, the block SHALL load rx_data from the shift register, set frm_err to the inverse of rx_sync, pulse rx_data_rdy, and go to IDLE.
REQ-018 All three updates in REQ-017 SHALL become visible on the clock edge that ends that enable cycle; rx_data_rdy is a registered output, high for exactly 1 clk.
REQ-019 rx_data and frm_err SHALL hold their values until the next STOP completion; a framing error still updates rx_data and pulses rx_data_rdy.
REQ-020 A stop bit sampled as 0 (break) SHALL NOT stall the FSM; it re-enters IDLE and may restart immediately if rx_sync stays low.
REQ-021 Back-to-back frames (start bit directly after stop) SHALL be received with no lost characters.
REQ-022 Nothing SHALL happen on clocks with baud_x16_en=0 other than synchronizer shifting and the rx_data_rdy pulse clearing.
REQ-023 No handshake SHALL exist for reading rx_data; a character not read before the next rx_data_rdy is overwritten.

Reset
REQ-024 While rst=1: state=IDLE, over_cnt=0, bit_cnt=0, shift register=0, rx_data=0, rx_data_rdy=0, frm_err=0, sync flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no rx_data_rdy pulse; after release, the block waits in IDLE for a new falling edge.

Verification (baud_x16_en every 4 clk, bit period 64 clk)
REQ-026 Apply rst and release it -> all outputs 0 and no rx_data_rdy pulse while rxd_i=1 for 2000 clk.
REQ-027 Send 8N1 frame 0x55 -> exactly one rx_data_rdy pulse, rx_data=0x55, frm_err=0, pulse within 1 bit period of the stop midpoint.
REQ-028 Send 0xA3 with stop bit driven 0 -> rx_data=0xA3, frm_err=1, one pulse; a following good frame 0x3C gives frm_err=0.
REQ-029 Pulse rxd_i low for 16 clk (4 ticks) then high -> no rx_data_rdy, FSM back in IDLE before the next tick after midpoint.
REQ-030 Send frames 0x00 then 0xFF back-to-back -> two pulses 640 clk apart, rx_data 0x00 then 0xFF, frm_err=0 both.
REQ-031 Assert rst during the 4th data bit of 0x81, then send 0x7E -> no pulse for 0x81; exactly one pulse with rx_data=0x7E.
